// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS main FSM and its datapath.
// The controller owns the master side; the datapath owns the slave side.
interface multicycle_control_if;
  logic [5:0] Op;
  logic       MemReady;
  logic       PcWrite;
  logic       PcWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IrWrite;
  logic       MemToReg;
  logic       RegDst;
  logic       RegWrite;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [1:0] PcSource;
  logic       ExtZero;
  logic [2:0] UC;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Op, MemReady,
    output PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite, MemToReg, RegDst,
           RegWrite, AluSrcA, AluSrcB, PcSource, ExtZero, UC, Illegal, State
  );

  modport slave (
    output Op, MemReady,
    input  PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite, MemToReg, RegDst,
           RegWrite, AluSrcA, AluSrcB, PcSource, ExtZero, UC, Illegal, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath. The state register is the only
// storage; every control output is decoded combinationally from state (plus Op and
// MemReady where a state needs them) and forced to zero while rst is high.
module multicycle_control #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StIExec    = 4'd8,
    StIWb      = 4'd9,
    StBranch   = 4'd10,
    StJump     = 4'd11
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;

  state_e r_state;
  state_e w_state_next;
  logic   w_mem_ready;

  // Single-cycle memory builds tie the handshake high.
  assign w_mem_ready = USE_MEM_READY ? bus.MemReady : 1'b1;
  assign bus.State   = r_state;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StFetch;
    else     r_state <= w_state_next;
  end

  // Next-state sequencing.
  always_comb begin
    w_state_next = StFetch;
    case (r_state)
      StFetch:    w_state_next = w_mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (bus.Op)
          OpRType:                        w_state_next = StRExec;
          OpLw, OpSw:                     w_state_next = StMemAddr;
          OpBeq:                          w_state_next = StBranch;
          OpJ:                            w_state_next = StJump;
          OpAddi, OpAndi, OpOri, OpSlti:  w_state_next = StIExec;
          default:                        w_state_next = StFetch;
        endcase
      end
      StMemAddr:  w_state_next = (bus.Op == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  w_state_next = w_mem_ready ? StMemWb : StMemRead;
      StMemWb:    w_state_next = StFetch;
      StMemWrite: w_state_next = w_mem_ready ? StFetch : StMemWrite;
      StRExec:    w_state_next = StRWb;
      StRWb:      w_state_next = StFetch;
      StIExec:    w_state_next = StIWb;
      StIWb:      w_state_next = StFetch;
      StBranch:   w_state_next = StFetch;
      StJump:     w_state_next = StFetch;
      default:    w_state_next = StFetch;
    endcase
  end

  // Control output decode, all zero during reset and in unused codes.
  always_comb begin
    bus.PcWrite     = 1'b0;
    bus.PcWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IrWrite     = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.AluSrcA     = 1'b0;
    bus.AluSrcB     = 2'b00;
    bus.PcSource    = 2'b00;
    bus.ExtZero     = 1'b0;
    bus.UC          = 3'b000;
    bus.Illegal     = 1'b0;
    if (!rst) begin
      case (r_state)
        StFetch: begin
          bus.MemRead = 1'b1;
          bus.AluSrcB = 2'b01;
          // PC and IR only update in the cycle the fetch completes.
          bus.IrWrite = w_mem_ready;
          bus.PcWrite = w_mem_ready;
        end
        StDecode: begin
          bus.AluSrcB = 2'b11;
          case (bus.Op)
            OpRType, OpLw, OpSw, OpBeq, OpJ,
            OpAddi, OpAndi, OpOri, OpSlti: bus.Illegal = 1'b0;
            default:                       bus.Illegal = 1'b1;
          endcase
        end
        StMemAddr: begin
          bus.AluSrcA = 1'b1;
          bus.AluSrcB = 2'b10;
        end
        StMemRead: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        StMemWb: begin
          bus.RegWrite = 1'b1;
          bus.MemToReg = 1'b1;
        end
        StMemWrite: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        StRExec: begin
          bus.AluSrcA = 1'b1;
          bus.UC      = 3'b111;
        end
        StRWb: begin
          bus.RegDst   = 1'b1;
          bus.RegWrite = 1'b1;
        end
        StIExec: begin
          bus.AluSrcA = 1'b1;
          bus.AluSrcB = 2'b10;
          case (bus.Op)
            OpAndi:  begin bus.UC = 3'b101; bus.ExtZero = 1'b1; end
            OpOri:   begin bus.UC = 3'b110; bus.ExtZero = 1'b1; end
            OpSlti:  bus.UC = 3'b010;
            default: bus.UC = 3'b000;
          endcase
        end
        StIWb: begin
          bus.RegWrite = 1'b1;
        end
        StBranch: begin
          bus.AluSrcA     = 1'b1;
          bus.UC          = 3'b001;
          bus.PcWriteCond = 1'b1;
          bus.PcSource    = 2'b01;
        end
        StJump: begin
          bus.PcWrite  = 1'b1;
          bus.PcSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for the multi-cycle MIPS control FSM: walks each instruction class
// through its state sequence and checks the decoded controls against hand values.
module tb_multicycle_control;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  multicycle_control_if bus ();

  multicycle_control #(
    .USE_MEM_READY(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run a zero-wait fetch with the given opcode, leaving the FSM in DECODE.
  task automatic do_fetch(input logic [5:0] op);
    bus.Op       = op;
    bus.MemReady = 1'b1;
    #1;
    check_eq("fetch_state", 32'(bus.State), 0);
    check_eq("fetch_irwrite", 32'(bus.IrWrite), 1);
    step();
    check_eq("decode_state", 32'(bus.State), 1);
  endtask

  localparam int NumI = 4;
  logic [5:0] i_ops   [NumI] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
  logic [2:0] i_uc    [NumI] = '{3'b000, 3'b101, 3'b110, 3'b010};
  logic       i_ext   [NumI] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.Op       = 6'b000000;
    bus.MemReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state", 32'(bus.State), 0);
    check_eq("reset_memread", 32'(bus.MemRead), 0);
    check_eq("reset_pcwrite", 32'(bus.PcWrite), 0);
    rst = 1'b0;
    #1;
    check_eq("post_reset_memread", 32'(bus.MemRead), 1);
    check_eq("post_reset_alusrcb", 32'(bus.AluSrcB), 1);

    // R-type: 0,1,6,7,0
    do_fetch(6'b000000);
    check_eq("decode_alusrcb", 32'(bus.AluSrcB), 3);
    check_eq("decode_regwrite", 32'(bus.RegWrite), 0);
    step();
    check_eq("rexec_state", 32'(bus.State), 6);
    check_eq("rexec_uc", 32'(bus.UC), 7);
    check_eq("rexec_alusrca", 32'(bus.AluSrcA), 1);
    check_eq("rexec_regwrite", 32'(bus.RegWrite), 0);
    step();
    check_eq("rwb_state", 32'(bus.State), 7);
    check_eq("rwb_regdst", 32'(bus.RegDst), 1);
    check_eq("rwb_regwrite", 32'(bus.RegWrite), 1);
    check_eq("rwb_memtoreg", 32'(bus.MemToReg), 0);
    step();
    check_eq("r_done_state", 32'(bus.State), 0);

    // lw with two wait cycles: 0,1,2,3,3,3,4,0
    do_fetch(6'b100011);
    step();
    check_eq("lw_addr_state", 32'(bus.State), 2);
    check_eq("lw_addr_alusrcb", 32'(bus.AluSrcB), 2);
    step();
    bus.MemReady = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_eq("lw_wait_state", 32'(bus.State), 3);
      check_eq("lw_wait_memread", 32'(bus.MemRead), 1);
      check_eq("lw_wait_iord", 32'(bus.IorD), 1);
      check_eq("lw_wait_regwrite", 32'(bus.RegWrite), 0);
      step();
    end
    bus.MemReady = 1'b1;
    #1;
    check_eq("lw_ready_state", 32'(bus.State), 3);
    step();
    check_eq("lw_wb_state", 32'(bus.State), 4);
    check_eq("lw_wb_memtoreg", 32'(bus.MemToReg), 1);
    check_eq("lw_wb_regwrite", 32'(bus.RegWrite), 1);
    check_eq("lw_wb_regdst", 32'(bus.RegDst), 0);
    step();
    check_eq("lw_done_state", 32'(bus.State), 0);

    // I-type sweep
    for (int k = 0; k < NumI; k++) begin
      do_fetch(i_ops[k]);
      step();
      check_eq("iexec_state", 32'(bus.State), 8);
      check_eq("iexec_uc", 32'(bus.UC), 32'(i_uc[k]));
      check_eq("iexec_extzero", 32'(bus.ExtZero), 32'(i_ext[k]));
      check_eq("iexec_alusrcb", 32'(bus.AluSrcB), 2);
      step();
      check_eq("iwb_state", 32'(bus.State), 9);
      check_eq("iwb_regwrite", 32'(bus.RegWrite), 1);
      check_eq("iwb_regdst", 32'(bus.RegDst), 0);
      step();
      check_eq("i_done_state", 32'(bus.State), 0);
    end

    // beq then j
    do_fetch(6'b000100);
    step();
    check_eq("beq_state", 32'(bus.State), 10);
    check_eq("beq_uc", 32'(bus.UC), 1);
    check_eq("beq_pcwritecond", 32'(bus.PcWriteCond), 1);
    check_eq("beq_pcsource", 32'(bus.PcSource), 1);
    check_eq("beq_pcwrite", 32'(bus.PcWrite), 0);
    step();
    check_eq("beq_done_state", 32'(bus.State), 0);
    do_fetch(6'b000010);
    step();
    check_eq("j_state", 32'(bus.State), 11);
    check_eq("j_pcwrite", 32'(bus.PcWrite), 1);
    check_eq("j_pcsource", 32'(bus.PcSource), 2);
    step();
    check_eq("j_done_state", 32'(bus.State), 0);

    // Fetch stall, then an illegal opcode
    bus.Op       = 6'b111111;
    bus.MemReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("stall_state", 32'(bus.State), 0);
      check_eq("stall_irwrite", 32'(bus.IrWrite), 0);
      check_eq("stall_pcwrite", 32'(bus.PcWrite), 0);
      step();
    end
    bus.MemReady = 1'b1;
    #1;
    check_eq("stall_done_irwrite", 32'(bus.IrWrite), 1);
    check_eq("stall_done_pcwrite", 32'(bus.PcWrite), 1);
    step();
    check_eq("illegal_state", 32'(bus.State), 1);
    check_eq("illegal_flag", 32'(bus.Illegal), 1);
    check_eq("illegal_irwrite", 32'(bus.IrWrite), 0);
    check_eq("illegal_regwrite", 32'(bus.RegWrite), 0);
    check_eq("illegal_memwrite", 32'(bus.MemWrite), 0);
    step();
    check_eq("illegal_next_state", 32'(bus.State), 0);
    check_eq("illegal_cleared", 32'(bus.Illegal), 0);

    // sw, reset asserted mid MEM_WRITE
    do_fetch(6'b101011);
    step();
    check_eq("sw_addr_state", 32'(bus.State), 2);
    step();
    bus.MemReady = 1'b0;
    #1;
    check_eq("sw_write_state", 32'(bus.State), 5);
    check_eq("sw_memwrite", 32'(bus.MemWrite), 1);
    check_eq("sw_memread", 32'(bus.MemRead), 0);
    check_eq("sw_regwrite", 32'(bus.RegWrite), 0);
    rst = 1'b1;
    #1;
    check_eq("midrst_state", 32'(bus.State), 0);
    check_eq("midrst_memwrite", 32'(bus.MemWrite), 0);
    check_eq("midrst_uc", 32'(bus.UC), 0);
    check_eq("midrst_memread", 32'(bus.MemRead), 0);
    step();
    rst = 1'b0;
    #1;
    check_eq("after_rst_state", 32'(bus.State), 0);
    check_eq("after_rst_memread", 32'(bus.MemRead), 1);
    check_eq("after_rst_iord", 32'(bus.IorD), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath; sits directly upstream of the ALU control decoder.
- Sequences fetch/decode/execute/memory/writeback from the 6-bit opcode of the instruction register.
- Drives all datapath enables and the 3-bit UC code consumed by the ALU control decoder.
- Supports variable-latency memory through a MemReady handshake.

Parameters:
- USE_MEM_READY, 1, when 0 MemReady is ignored and treated as constant 1 (single-cycle memory).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Op  in  6  opcode field, Instruction[31:26], from the instruction register. Stable outside FETCH.
- MemReady  in  1  memory access completes this cycle.
- PcWrite  out  1  unconditional PC load.
- PcWriteCond  out  1  PC load qualified by ALU Zero (beq).
- IorD  out  1  memory address mux: 0=PC, 1=ALUOut.
- MemRead / MemWrite  out  1 each  memory strobes, held until MemReady.
- IrWrite  out  1  instruction register load.
- MemToReg  out  1  writeback mux: 1=MDR, 0=ALUOut.
- RegDst  out  1  destination register: 1=rd, 0=rt.
- RegWrite  out  1  register file write enable.
- AluSrcA  out  1  ALU A: 0=PC, 1=rs.
- AluSrcB  out  2  ALU B: 00=rt, 01=4, 10=imm, 11=imm<<2.
- PcSource  out  2  PC mux: 00=ALU, 01=ALUOut, 10=jump target.
- ExtZero  out  1  immediate zero-extend (andi/ori).
- UC  out  3  ALU control code: 111=R-type funct decode, 000=add, 001=sub, 010=slt, 101=and, 110=or.
- Illegal  out  1  one-cycle pulse on an undefined opcode.
- State  out  4  current state, for debug.

Behaviour:
- The state register is the only storage. All outputs are combinational from state, plus Op/MemReady where noted.
- Outputs not listed for a state are 0. UC defaults to 000.
- Reset: rst=1 forces state=FETCH asynchronously and gates every output to 0 (UC=000, State=0). The first FETCH outputs appear the cycle after rst deasserts. Reset mid-instruction abandons it with no writes.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11. Codes 12-15: all outputs 0, next state FETCH.
- FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, UC=000, PcSource=00.
  - IrWrite and PcWrite are asserted only in the cycle MemReady=1; that cycle advances to DECODE.
  - Otherwise the FSM stays in FETCH with no PC/IR update.
- DECODE: AluSrcA=0, AluSrcB=11, UC=000 (branch target). Next state by Op:
  - 000000 -> R_EXEC
  - 100011 (lw), 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi), 001100 (andi), 001101 (ori), 001010 (slti) -> I_EXEC
  - any other Op: Illegal=1 this cycle, next FETCH.
- MEM_ADDR: AluSrcA=1, AluSrcB=10, UC=000. Next MEM_READ if lw, MEM_WRITE if sw.
- MEM_READ: MemRead=1, IorD=1. Wait for MemReady, then MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0. Next FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Wait for MemReady, then FETCH.
- R_EXEC: AluSrcA=1, AluSrcB=00, UC=111. Next R_WB.
- R_WB: RegDst=1, RegWrite=1, MemToReg=0. Next FETCH.
- I_EXEC: AluSrcA=1, AluSrcB=10. Next I_WB.
  - UC: addi->000, andi->101, ori->110, slti->010.
  - ExtZero=1 for andi/ori only.
- I_WB: RegDst=0, RegWrite=1, MemToReg=0. Next FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, UC=001, PcWriteCond=1, PcSource=01. Next FETCH.
- JUMP: PcWrite=1, PcSource=10. Next FETCH.
- Minimum cycles with zero-wait memory: R=4, lw=5, sw=4, I-type=4, beq=3, j=3. Each memory wait cycle adds 1.
- MemReady outside FETCH/MEM_READ/MEM_WRITE is ignored.
- MemRead and MemWrite are never both 1.
- RegWrite is never 1 in the same cycle as MemWrite.

Test Plan:
- Reset: rst pulsed mid-MEM_WRITE with MemReady=0 -> state=0 immediately, MemWrite=0, UC=000. After release the next cycle shows MemRead=1, IorD=0.
- R-type add: Op=000000, MemReady=1 -> states 0,1,6,7,0. UC=111 in R_EXEC. RegDst=1 and RegWrite=1 only in R_WB.
- lw with 2-cycle memory wait: Op=100011, MemReady low 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0. MemToReg=1 and RegWrite=1 in state 4 only.
- I-type sweep: Op=001000/001100/001101/001010 -> in I_EXEC UC=000/101/110/010 and ExtZero=0/1/1/0.
- beq then j: Op=000100 -> BRANCH with UC=001, PcWriteCond=1, PcSource=01, 3 cycles. Op=000010 -> JUMP with PcWrite=1, PcSource=10.
- Fetch stall and illegal opcode: MemReady=0 for 3 cycles in FETCH -> IrWrite=0 and PcWrite=0 throughout, then both 1 for exactly one cycle. Op=111111 -> Illegal=1 in DECODE, next state FETCH, no RegWrite/MemWrite.
